// File: rtl/synapse_scheduler_fifo.sv
// Serialises one latched neuron-state frame into per-neuron control/address tokens.
// Latency: frame accepted at E0, first token written at E1, visible after E1 (no fall-through).
// Backpressure: SCAN stalls while the output FIFO is full with no read; frame input ready only in IDLE.
module synapse_scheduler_fifo #(
  parameter int NA        = 4,
  parameter int NS        = 2,
  parameter int DEPTH     = 4,
  parameter int SKIP_ZERO = 1,
  localparam int AW = (NA > 1) ? $clog2(NA) : 1,
  localparam int TW = 2 + NS + AW,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iValid_AS_State,
  output logic            oReady_AS_State,
  input  logic [NA*NS-1:0] iData_AS_State,
  output logic            oValid_BM_Ctrl_Addr,
  input  logic            iReady_BM_Ctrl_Addr,
  output logic [TW-1:0]   oData_BM_Ctrl_Addr,
  output logic [LW-1:0]   oLevel,
  output logic            oBusy
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  state_e             state_q, state_d;
  logic               rdy_en_q;
  logic [NA*NS-1:0]   frame_q, frame_d;
  logic [NA-1:0]      mask_q, mask_d;
  logic               first_q, first_d;
  logic               null_q, null_d;
  logic [TW-1:0]      mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q, level_d;

  logic               rd_en, wr_en, can_wr, last_tok;
  logic [TW-1:0]      wr_dat;
  logic [AW-1:0]      sel_idx;
  logic [NS-1:0]      sel_state;
  logic [NA-1:0]      mask_in;

  assign oValid_BM_Ctrl_Addr = (level_q != '0);
  assign oData_BM_Ctrl_Addr  = oValid_BM_Ctrl_Addr ? mem_q[rd_ptr_q] : '0;
  assign oLevel              = level_q;
  assign oBusy               = (state_q == ST_SCAN) || (level_q != '0);

  assign rd_en    = oValid_BM_Ctrl_Addr && iReady_BM_Ctrl_Addr;
  assign can_wr   = (level_q != LW'(DEPTH)) || rd_en;
  assign last_tok = ((mask_q & (mask_q - NA'(1))) == '0);

  // Pick the lowest active neuron and build the acceptance mask for an incoming frame.
  always_comb begin
    sel_idx   = '0;
    sel_state = '0;
    mask_in   = '0;
    for (int i = NA - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_idx   = AW'(i);
        sel_state = frame_q[i*NS +: NS];
      end
    end
    for (int i = 0; i < NA; i++) begin
      mask_in[i] = (SKIP_ZERO != 0) ? (|iData_AS_State[i*NS +: NS]) : 1'b1;
    end
  end

  // Scheduler next-state: accept a frame in IDLE, emit one token per writable cycle in SCAN.
  always_comb begin
    state_d         = state_q;
    frame_d         = frame_q;
    mask_d          = mask_q;
    first_d         = first_q;
    null_d          = null_q;
    wr_en           = 1'b0;
    wr_dat          = '0;
    oReady_AS_State = 1'b0;
    case (state_q)
      ST_IDLE: begin
        oReady_AS_State = rdy_en_q;
        if (iValid_AS_State && rdy_en_q) begin
          frame_d = iData_AS_State;
          mask_d  = mask_in;
          null_d  = (mask_in == '0);
          first_d = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (can_wr) begin
          wr_en = 1'b1;
          if (null_q) begin
            wr_dat  = {1'b1, 1'b1, {(NS+AW){1'b0}}};
            null_d  = 1'b0;
            first_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            wr_dat  = {first_q, last_tok, sel_state, sel_idx};
            mask_d  = mask_q & ~(NA'(1) << sel_idx);
            first_d = 1'b0;
            if (last_tok) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO occupancy: a simultaneous read and write leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state, latched frame and FIFO pointers; everything is discarded on reset.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      frame_q  <= '0;
      mask_q   <= '0;
      first_q  <= 1'b0;
      null_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      frame_q  <= frame_d;
      mask_q   <= mask_d;
      first_q  <= first_d;
      null_q   <= null_d;
      level_q  <= level_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Token storage; contents are only observable through a valid level, so no reset needed.
  always_ff @(posedge iCLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: tb/tb_synapse_scheduler_fifo.sv
module tb_synapse_scheduler_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: NA=4 NS=2 DEPTH=4 SKIP_ZERO=1
  logic       a_vld_i, a_rdy_o, a_vld_o, a_rdy_i, a_busy;
  logic [7:0] a_dat_i;
  logic [5:0] a_dat_o;
  logic [2:0] a_lvl;
  // Instance B: NA=4 NS=2 DEPTH=4 SKIP_ZERO=0
  logic       b_vld_i, b_rdy_o, b_vld_o, b_rdy_i, b_busy;
  logic [7:0] b_dat_i;
  logic [5:0] b_dat_o;
  logic [2:0] b_lvl;
  // Instance C: NA=8 NS=1 DEPTH=4 SKIP_ZERO=1
  logic       c_vld_i, c_rdy_o, c_vld_o, c_rdy_i, c_busy;
  logic [7:0] c_dat_i;
  logic [5:0] c_dat_o;
  logic [2:0] c_lvl;

  synapse_scheduler_fifo #(.NA(4), .NS(2), .DEPTH(4), .SKIP_ZERO(1)) u_a (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AS_State(a_vld_i), .oReady_AS_State(a_rdy_o), .iData_AS_State(a_dat_i),
    .oValid_BM_Ctrl_Addr(a_vld_o), .iReady_BM_Ctrl_Addr(a_rdy_i), .oData_BM_Ctrl_Addr(a_dat_o),
    .oLevel(a_lvl), .oBusy(a_busy));

  synapse_scheduler_fifo #(.NA(4), .NS(2), .DEPTH(4), .SKIP_ZERO(0)) u_b (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AS_State(b_vld_i), .oReady_AS_State(b_rdy_o), .iData_AS_State(b_dat_i),
    .oValid_BM_Ctrl_Addr(b_vld_o), .iReady_BM_Ctrl_Addr(b_rdy_i), .oData_BM_Ctrl_Addr(b_dat_o),
    .oLevel(b_lvl), .oBusy(b_busy));

  synapse_scheduler_fifo #(.NA(8), .NS(1), .DEPTH(4), .SKIP_ZERO(1)) u_c (
    .iCLK(clk), .iRST(rst_n),
    .iValid_AS_State(c_vld_i), .oReady_AS_State(c_rdy_o), .iData_AS_State(c_dat_i),
    .oValid_BM_Ctrl_Addr(c_vld_o), .iReady_BM_Ctrl_Addr(c_rdy_i), .oData_BM_Ctrl_Addr(c_dat_o),
    .oLevel(c_lvl), .oBusy(c_busy));

  int n_chk  = 0;
  int n_fail = 0;
  logic [5:0] qa[$];
  logic [5:0] qb[$];
  logic [5:0] qc[$];
  logic rand_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_rdy(input int which);
    case (which)
      0:       return a_rdy_o;
      1:       return b_rdy_o;
      default: return c_rdy_o;
    endcase
  endfunction

  function automatic logic cur_busy(input int which);
    case (which)
      0:       return (qa.size() != 0) || a_vld_o;
      1:       return (qb.size() != 0) || b_vld_o;
      default: return (qc.size() != 0) || c_vld_o;
    endcase
  endfunction

  task automatic send(input int which, input logic [7:0] d);
    int n;
    n = 0;
    case (which)
      0:       begin a_dat_i = d; a_vld_i = 1'b1; end
      1:       begin b_dat_i = d; b_vld_i = 1'b1; end
      default: begin c_dat_i = d; c_vld_i = 1'b1; end
    endcase
    while (!cur_rdy(which) && n < 200) begin
      tick();
      n++;
    end
    chk("accept_within_budget", {31'd0, n < 200}, 32'd1);
    tick();
    a_vld_i = 1'b0;
    b_vld_i = 1'b0;
    c_vld_i = 1'b0;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (cur_busy(which) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_within_budget", {31'd0, n < 500}, 32'd1);
  endtask

  task automatic push_ff();
    qa.push_back(6'b101100); qa.push_back(6'b001101);
    qa.push_back(6'b001110); qa.push_back(6'b011111);
  endtask

  task automatic push_79();
    qa.push_back(6'b100100); qa.push_back(6'b001001);
    qa.push_back(6'b001110); qa.push_back(6'b010111);
  endtask

  // Scoreboard monitors: compare each transferring token against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_vld_o && a_rdy_i) begin
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_unexpected_token: got %0h expected none", a_dat_o);
        end else chk("a_token", {26'd0, a_dat_o}, {26'd0, qa.pop_front()});
      end
      chk("a_level_max4", {31'd0, a_lvl <= 3'd4}, 32'd1);
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_vld_o && b_rdy_i) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_token: got %0h expected none", b_dat_o);
      end else chk("b_token", {26'd0, b_dat_o}, {26'd0, qb.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_vld_o && c_rdy_i) begin
      if (qc.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL c_unexpected_token: got %0h expected none", c_dat_o);
      end else chk("c_token", {26'd0, c_dat_o}, {26'd0, qc.pop_front()});
    end
  end

  // Random sink readiness during the streaming phase.
  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      a_rdy_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_vld_i = 1'b0; b_vld_i = 1'b0; c_vld_i = 1'b0;
    a_rdy_i = 1'b1; b_rdy_i = 1'b1; c_rdy_i = 1'b1;
    a_dat_i = '0;   b_dat_i = '0;   c_dat_i = '0;
    #1;
    chk("rst_ready", {31'd0, a_rdy_o}, 32'd0);
    chk("rst_valid", {31'd0, a_vld_o}, 32'd0);
    chk("rst_data",  {26'd0, a_dat_o}, 32'd0);
    chk("rst_level", {29'd0, a_lvl},   32'd0);
    chk("rst_busy",  {31'd0, a_busy},  32'd0);
    tick(); tick();
    rst_n = 1'b1;
    chk("ready_before_first_edge", {31'd0, a_rdy_o}, 32'd0);
    tick();
    chk("ready_after_first_edge", {31'd0, a_rdy_o}, 32'd1);

    // Sparse frame with latency and throughput checks
    qa.push_back(6'b100101);
    qa.push_back(6'b011011);
    a_dat_i = 8'b10_00_01_00;
    a_vld_i = 1'b1;
    tick();                                   // E0: accept
    a_vld_i = 1'b0;
    chk("sparse_valid_at_accept", {31'd0, a_vld_o}, 32'd0);
    chk("sparse_ready_in_scan",   {31'd0, a_rdy_o}, 32'd0);
    tick();                                   // E1: first token written
    chk("sparse_valid_after_e1",  {31'd0, a_vld_o}, 32'd1);
    chk("sparse_busy_after_e1",   {31'd0, a_busy},  32'd1);
    chk("sparse_ready_after_e1",  {31'd0, a_rdy_o}, 32'd0);
    tick();                                   // E2: last token written
    chk("sparse_ready_after_e2",  {31'd0, a_rdy_o}, 32'd1);
    drain(0);

    // Null frame, skip-zero enabled
    qa.push_back(6'b110000);
    send(0, 8'h00);
    drain(0);

    // Null frame, skip-zero disabled: every neuron emitted
    qb.push_back(6'b100000); qb.push_back(6'b000001);
    qb.push_back(6'b000010); qb.push_back(6'b010011);
    send(1, 8'h00);
    drain(1);

    // NS=1, NA=8: first and last neurons only
    qc.push_back(6'b101000);
    qc.push_back(6'b011111);
    send(2, 8'b1000_0001);
    drain(2);

    // Back-pressure: fill the FIFO, then stall a second frame in SCAN
    a_rdy_i = 1'b0;
    push_79();
    push_79();
    send(0, 8'b01_11_10_01);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_level_full",  {29'd0, a_lvl},   32'd4);
    chk("bp_head",        {26'd0, a_dat_o}, 32'h24);
    send(0, 8'b01_11_10_01);
    tick(); tick(); tick();
    chk("bp_ready_stall", {31'd0, a_rdy_o}, 32'd0);
    chk("bp_level_hold",  {29'd0, a_lvl},   32'd4);
    chk("bp_head_hold",   {26'd0, a_dat_o}, 32'h24);
    chk("bp_busy",        {31'd0, a_busy},  32'd1);
    a_rdy_i = 1'b1;
    tick();
    a_rdy_i = 1'b0;
    chk("bp_level_rw",    {29'd0, a_lvl},   32'd4);
    chk("bp_head_next",   {26'd0, a_dat_o}, 32'h09);
    tick(); tick();
    chk("bp_level_rw_hold", {29'd0, a_lvl}, 32'd4);
    chk("bp_ready_still",   {31'd0, a_rdy_o}, 32'd0);
    a_rdy_i = 1'b1;
    drain(0);

    // Reset mid-SCAN with two tokens queued
    a_rdy_i = 1'b0;
    push_ff();
    send(0, 8'hFF);
    tick(); tick();
    chk("mid_level_two", {29'd0, a_lvl},   32'd2);
    chk("mid_in_scan",   {31'd0, a_rdy_o}, 32'd0);
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("mid_rst_ready", {31'd0, a_rdy_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, a_vld_o}, 32'd0);
    chk("mid_rst_data",  {26'd0, a_dat_o}, 32'd0);
    chk("mid_rst_level", {29'd0, a_lvl},   32'd0);
    chk("mid_rst_busy",  {31'd0, a_busy},  32'd0);
    tick();
    rst_n = 1'b1;
    a_rdy_i = 1'b1;
    chk("mid_rel_ready_low", {31'd0, a_rdy_o}, 32'd0);
    tick();
    chk("mid_rel_ready", {31'd0, a_rdy_o}, 32'd1);
    chk("mid_rel_level", {29'd0, a_lvl},   32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_no_stale",  {31'd0, a_vld_o}, 32'd0);

    // Stream five full frames under random sink readiness
    rand_on = 1'b1;
    for (int f = 0; f < 5; f++) begin
      if (f % 2 == 0) begin
        push_ff();
        send(0, 8'hFF);
      end else begin
        push_79();
        send(0, 8'b01_11_10_01);
      end
    end
    rand_on = 1'b0;
    tick();
    a_rdy_i = 1'b1;
    drain(0);

    chk("qa_empty", qa.size(), 32'd0);
    chk("qb_empty", qb.size(), 32'd0);
    chk("qc_empty", qc.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/synapse_scheduler_fifo.md
Name: synapse_scheduler_fifo

Overview:
- Parametrised successor to the neuron-state synapse scheduler.
- Latches one NA-entry neuron-state frame and serialises it into one control/address token per active neuron, in ascending index order.
- Tokens carry first/last burst markers and pass through a DEPTH-entry output FIFO to the synapse-memory controller.
- Adds generic per-neuron state width, optional zero-skip, null-frame markers and FIFO fill-level reporting.

Parameters:
- NA, 4: number of neurons per frame (>=2).
- NS, 2: state bits per neuron (2 = rc signed spike, 1 = plain spike).
- DEPTH, 4: output FIFO entries (power of two, >=2).
- SKIP_ZERO, 1: 1 = emit only neurons with nonzero state; 0 = emit all NA neurons.
- Derived: AW = max(1, clog2(NA)); TW = 2+NS+AW; LW = clog2(DEPTH)+1.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset.
- iValid_AS_State  in  1  frame valid.
- oReady_AS_State  out  1  frame ready.
- iData_AS_State  in  NA*NS  frame; neuron i occupies bits [i*NS +: NS].
- oValid_BM_Ctrl_Addr  out  1  token valid.
- iReady_BM_Ctrl_Addr  in  1  token ready.
- oData_BM_Ctrl_Addr  out  TW  token = {first, last, state[NS-1:0], addr[AW-1:0]}, MSB first.
- oLevel  out  LW  current FIFO occupancy.
- oBusy  out  1  high while in SCAN or while the FIFO is non-empty.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While iRST is low:
  - FSM returns to IDLE; latched frame, mask and FIFO pointers clear.
  - oReady_AS_State=0, oValid_BM_Ctrl_Addr=0, oData_BM_Ctrl_Addr=0, oLevel=0, oBusy=0.
  - oReady_AS_State rises on the first edge after deassertion.
  - Reset mid-frame or with FIFO contents discards everything; no partial burst is resumed.
- Handshakes: a transfer occurs on a rising edge with valid&ready both high. Sources hold data stable while valid&!ready. oValid_BM_Ctrl_Addr never drops without a transfer. oData_BM_Ctrl_Addr is the FIFO head and is stable while valid.
- FSM state IDLE:
  - oReady_AS_State=1.
  - On accept, latch the frame and build mask m: m[i] = (state_i != 0) if SKIP_ZERO=1, else all ones.
  - Go to SCAN.
- FSM state SCAN:
  - oReady_AS_State=0.
  - Each cycle in which the FIFO can accept a write (not full, or a read on the same edge), write one token:
    - addr = lowest set index in m; state = latched state of that neuron.
    - first = 1 on the first token of the frame.
    - last = 1 when m has exactly one bit set.
  - Clear that bit of m. After writing the last token, return to IDLE on the same edge.
  - Null frame: if m == 0 on entry (possible only with SKIP_ZERO=1), write exactly one token {first=1, last=1, state=0, addr=0}, then return to IDLE.
  - If the FIFO is full with no read, SCAN stalls; m is unchanged.
- Latency and throughput:
  - Frame accepted at edge E0 -> first token written at E1 -> oValid_BM_Ctrl_Addr high after E1.
  - With no back-pressure, a frame with k active neurons takes k SCAN cycles; the next frame is accepted at the earliest k cycles after E1 (k+1 cycles per frame).
- FIFO:
  - Circular buffer, pointers wrap modulo DEPTH.
  - oValid_BM_Ctrl_Addr = (oLevel != 0).
  - oLevel: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - Full (oLevel == DEPTH) with a same-edge read: the write is allowed.
  - Empty: no read occurs; a write makes the token visible the next cycle (no fall-through).
- Ordering: tokens leave in strictly ascending addr within a frame; frames never interleave.

Test Plan:
- Reset: NA=4, NS=2; drive iRST low mid-SCAN with 2 tokens queued -> all outputs 0 immediately; after release oLevel=0, oReady_AS_State=1, no stale token appears.
- Sparse frame: SKIP_ZERO=1, states {n0=0, n1=2'b01, n2=0, n3=2'b10}, iReady_BM_Ctrl_Addr=1 -> tokens {1,0,01,1} then {0,1,10,3}; oValid_BM_Ctrl_Addr first high one cycle after accept; next frame accepted 2 cycles after the first write.
- Null frame: all-zero states, SKIP_ZERO=1 -> exactly one token {1,1,00,0}. With SKIP_ZERO=0 -> 4 tokens, addr 0..3, state 0, first on addr 0, last on addr 3.
- Back-pressure: DEPTH=4, all 4 neurons active, iReady_BM_Ctrl_Addr=0 -> oLevel rises to 4 and holds, head stays {1,0,s0,0}, oReady_AS_State stays 0. Raise ready for 1 cycle -> one read and a same-edge write; oLevel stays 4.
- Wrap and stream: 5 consecutive full frames with random ready (~50%) -> scoreboard matches every token in order; FIFO pointers wrap more than once; oLevel never exceeds 4.
- NS=1, NA=8: frame 8'b1000_0001 -> tokens addr 0 (first) then addr 7 (last); TW = 2+1+3 = 6.
